// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants, tile-grid geometry and output record.
package vga_timing_pkg;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_TILE_W   = 10;
  localparam int DEF_TILE_H   = 15;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
  localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

  localparam int TILE_COLS = 64;
  localparam int TILE_ROWS = 32;
  localparam int COL_W     = $clog2(TILE_COLS);
  localparam int ROW_W     = $clog2(TILE_ROWS);
  localparam int RGB_W     = 12;

  typedef logic [RGB_W-1:0] rgb_t;

  // Everything that leaves the block pixel-aligned travels together so the
  // sync pulses and colour can never drift apart.
  typedef struct packed {
    logic hsync;
    logic vsync;
    rgb_t rgb;
  } vga_out_t;

  localparam vga_out_t VGA_OUT_IDLE = '{hsync: 1'b1, vsync: 1'b1, rgb: '0};

endpackage

// File: rtl/tile_counter.sv
// Splits a stream of pixel or line increments into STEP-wide tiles and keeps
// the current tile index, using only compare/increment logic.
module tile_counter #(
  parameter int STEP  = 10,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [IDX_W-1:0] idx_o
);

  localparam int SUB_W = (STEP > 1) ? $clog2(STEP) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(STEP - 1);

  logic [SUB_W-1:0] sub_q, sub_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Clear wins over increment so a line/frame wrap always restarts at tile 0.
  always_comb begin
    sub_d = sub_q;
    idx_d = idx_q;
    if (clr_i) begin
      sub_d = '0;
      idx_d = '0;
    end else if (inc_i) begin
      if (sub_q == SUB_LAST) begin
        sub_d = '0;
        idx_d = idx_q + 1'b1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= '0;
      idx_q <= '0;
    end else begin
      sub_q <= sub_d;
      idx_q <= idx_d;
    end
  end

  assign idx_o = idx_q;

endmodule

// File: rtl/vga_tile_scanner.sv
// VGA timing generator that walks the screen as a tile grid, addresses an
// overlay ROM and drives pixel-aligned sync and colour to the panel.
module vga_tile_scanner
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int TILE_W   = DEF_TILE_W,
  parameter int TILE_H   = DEF_TILE_H
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RGB_W-1:0] color_data,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb,
  output logic             pixel_tick,
  output logic             frame_start
);

  localparam int HTOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VTOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW   = $clog2(HTOT);
  localparam int VW   = $clog2(VTOT);
  localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(HTOT - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(VTOT - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_LO    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_HI    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_LO    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_HI    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0]    div_q, div_d;
  logic [HW-1:0]    h_q, h_d;
  logic [VW-1:0]    v_q, v_d;
  vga_out_t         out_q, out_d;

  logic             h_last, v_last;
  logic             video_on, hsync_n, vsync_n;
  logic [COL_W-1:0] col_idx;
  logic [ROW_W-1:0] row_idx;

  assign pixel_tick = (div_q == DIV_LAST);
  assign div_d      = pixel_tick ? '0 : div_q + 1'b1;

  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pixel_tick) begin
      h_d = h_last ? '0 : h_q + 1'b1;
      if (h_last) begin
        v_d = v_last ? '0 : v_q + 1'b1;
      end
    end
  end

  tile_counter #(
    .STEP  (TILE_W),
    .IDX_W (COL_W)
  ) u_col_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (pixel_tick),
    .clr_i (pixel_tick & h_last),
    .idx_o (col_idx)
  );

  tile_counter #(
    .STEP  (TILE_H),
    .IDX_W (ROW_W)
  ) u_row_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (pixel_tick & h_last),
    .clr_i (pixel_tick & h_last & v_last),
    .idx_o (row_idx)
  );

  assign video_on = (h_q < H_ACT) && (v_q < V_ACT);
  assign hsync_n  = !((h_q >= HS_LO) && (h_q <= HS_HI));
  assign vsync_n  = !((v_q >= VS_LO) && (v_q <= VS_HI));

  // The tile indices keep counting through blanking; mask them so the ROM
  // only ever sees in-range addresses.
  assign col = video_on ? col_idx : '0;
  assign row = video_on ? row_idx : '0;

  // Sampling on the tick edge gives the ROM a full pixel period after the
  // address change, and a single register stage keeps sync and colour aligned.
  always_comb begin
    out_d = out_q;
    if (pixel_tick) begin
      out_d.rgb   = video_on ? color_data : '0;
      out_d.hsync = hsync_n;
      out_d.vsync = vsync_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      out_q <= VGA_OUT_IDLE;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      out_q <= out_d;
    end
  end

  assign frame_start = pixel_tick && h_last && v_last;
  assign hsync       = out_q.hsync;
  assign vsync       = out_q.vsync;
  assign rgb         = out_q.rgb;

endmodule
